// File: rtl/uart_rx_param.sv
// UART receiver: runtime baud divisor, start-glitch reject, sticky errors.
// Optional parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pin,
  input  logic [DIV_W-1:0]     div,
  input  logic                 rd,
  input  logic                 err_clr,
  input  logic [7:0]           ctrl,
  output logic [DATA_BITS-1:0] data,
  output logic [7:0]           state
);

  localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } st_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } st_t;
`endif

  st_t                  st;
  logic                 sync1;
  logic                 rxs;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     dlat;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] sh;
  logic                 busy;
  logic                 contains_data;
  logic                 overrun;
  logic                 frame_err;
  logic                 parity_bit;
  logic [DIV_W-1:0]     d_eff;
  logic                 last_full;
  logic                 last_half;

  assign d_eff = (div < DIV_W'(4)) ? DIV_W'(4) : div;
  assign last_full = (cnt == dlat - DIV_W'(1));
  assign last_half = (cnt == (dlat >> 1) - DIV_W'(1));

`ifdef UART_RX_PARITY_EN
  logic par_on;
  logic par_odd;
  logic parity_err;
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[4:3];
  assign parity_bit  = parity_err;
`else
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[4:1];
  assign parity_bit  = 1'b0;
`endif

  assign state = {ctrl[7:5], parity_bit, frame_err,
                  overrun, contains_data, busy};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      st            <= IDLE;
      sync1         <= 1'b1;
      rxs           <= 1'b1;
      cnt           <= '0;
      dlat          <= DIV_W'(4);
      bitcnt        <= '0;
      sh            <= '0;
      data          <= '0;
      busy          <= 1'b0;
      contains_data <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_on        <= 1'b0;
      par_odd       <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      sync1 <= pin;
      rxs   <= sync1;
      if (rd) contains_data <= 1'b0;
      // Clears come first so a same-cycle error set below wins.
      if (err_clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (st)
        IDLE: begin
          busy <= 1'b0;
          cnt  <= '0;
          if (ctrl[0] && !rxs) begin
            st     <= START;
            busy   <= 1'b1;
            dlat   <= d_eff;
            bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_on  <= ctrl[2];
            par_odd <= ctrl[1];
`endif
          end
        end
        START: begin
          if (last_half) begin
            cnt <= '0;
            if (rxs) begin
              st   <= IDLE;
              busy <= 1'b0;
            end else begin
              st <= DATA;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (last_full) begin
            cnt    <= '0;
            sh     <= {rxs, sh[DATA_BITS-1:1]};
            bitcnt <= bitcnt + BW'(1);
            if (bitcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              st <= par_on ? PARITY : STOP;
`else
              st <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (last_full) begin
            cnt <= '0;
            st  <= STOP;
            if (rxs != ((^sh) ^ par_odd)) parity_err <= 1'b1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
`endif
        STOP: begin
          if (last_full) begin
            cnt           <= '0;
            data          <= sh;
            contains_data <= 1'b1;
            if (contains_data && !rd) overrun <= 1'b1;
            if (rxs) begin
              st   <= IDLE;
              busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              st        <= BREAK;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        BREAK: begin
          if (rxs) begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (8 data bits, 16-bit divisor).
// Parity checks switch on UART_RX_PARITY_EN.
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pin;
  logic [15:0] div;
  logic        rd;
  logic        err_clr;
  logic [7:0]  ctrl;
  logic [7:0]  data;
  logic [7:0]  state;

  int errors = 0;
  int checks = 0;

  uart_rx_param #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .pin     (pin),
    .div     (div),
    .rd      (rd),
    .err_clr (err_clr),
    .ctrl    (ctrl),
    .data    (data),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pin = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Edge k counts posedges after the start bit is driven; rise is the
  // first edge whose registered contains_data is 1 (-1 if none).
  task automatic send_frame(input logic [7:0] w, input int d,
                            input bit par, input bit pbit,
                            input bit stopv, input int rd_edge,
                            output int rise);
    logic [11:0] bits;
    int n;
    int k;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = w[i];
    n = 9;
    if (par) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stopv;
    n++;
    rise = -1;
    k = 0;
    for (int b = 0; b < n; b++) begin
      pin = bits[b];
      for (int j = 0; j < d; j++) begin
        @(posedge clk);
        #1;
        k++;
        if (rise < 0 && state[1] === 1'b1) rise = k;
        rd = (k == rd_edge - 1);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    pin = 1'b1;
    div = 16'd8;
    rd = 1'b0;
    err_clr = 1'b0;
    ctrl = 8'h01;
    repeat (3) tick();
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", data);
    end
    checks++;
    if (state !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %h expected 00", state);
    end
    resetn = 1'b0;
    idle(4);
  endtask

  task automatic test_basic();
    int rise;
    ctrl = 8'hA1;
    div = 16'd8;
    send_frame(8'hA5, 8, 0, 0, 1, 0, rise);
    idle(4);
    // 3 sync/idle edges + 4 half bit + 9 bits * 8 = 79.
    checks++;
    if (rise !== 79) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 79", rise);
    end
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_data: got %h expected a5", data);
    end
    checks++;
    if (state !== 8'hA2) begin
      errors++;
      $display("FAIL basic_state: got %h expected a2", state);
    end
    pulse_rd();
    checks++;
    if (state[1] !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd: got %b expected 0", state[1]);
    end
    ctrl = 8'h01;
  endtask

  task automatic test_glitch();
    div = 16'd16;
    pin = 1'b0;
    tick();
    tick();
    pin = 1'b1;
    repeat (3) tick();
    checks++;
    if (state[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_in: got %b expected 1", state[0]);
    end
    idle(10);
    checks++;
    if (state !== 8'h00) begin
      errors++;
      $display("FAIL glitch_state: got %h expected 00", state);
    end
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL glitch_data: got %h expected a5", data);
    end
  endtask

  task automatic test_min_div();
    int rise;
    div = 16'd2;
    send_frame(8'h96, 4, 0, 0, 1, 0, rise);
    idle(6);
    checks++;
    if (data !== 8'h96) begin
      errors++;
      $display("FAIL mindiv_data: got %h expected 96", data);
    end
    pulse_rd();
    div = 16'd8;
  endtask

  task automatic test_back_to_back();
    int rise;
    send_frame(8'h11, 8, 0, 0, 1, 0, rise);
    send_frame(8'h22, 8, 0, 0, 1, 0, rise);
    idle(4);
    checks++;
    if (data !== 8'h22) begin
      errors++;
      $display("FAIL b2b_data: got %h expected 22", data);
    end
    checks++;
    if (state[2:1] !== 2'b11) begin
      errors++;
      $display("FAIL b2b_overrun: got %b expected 11", state[2:1]);
    end
    pulse_clr();
    checks++;
    if (state[2:1] !== 2'b01) begin
      errors++;
      $display("FAIL b2b_clr: got %b expected 01", state[2:1]);
    end
    // rd lands on the stop-sample edge (79): load wins, no overrun.
    send_frame(8'h33, 8, 0, 0, 1, 79, rise);
    idle(4);
    checks++;
    if (state[2:1] !== 2'b01) begin
      errors++;
      $display("FAIL rd_at_load: got %b expected 01", state[2:1]);
    end
    checks++;
    if (data !== 8'h33) begin
      errors++;
      $display("FAIL rd_at_load_data: got %h expected 33", data);
    end
    pulse_rd();
  endtask

  task automatic test_break();
    int rise;
    send_frame(8'h81, 8, 0, 0, 0, 0, rise);
    pin = 1'b0;
    repeat (400) tick();
    checks++;
    if (state !== 8'h0B) begin
      errors++;
      $display("FAIL break_state: got %h expected 0b", state);
    end
    checks++;
    if (data !== 8'h81) begin
      errors++;
      $display("FAIL break_data: got %h expected 81", data);
    end
    idle(5);
    checks++;
    if (state[0] !== 1'b0) begin
      errors++;
      $display("FAIL break_exit: got %b expected 0", state[0]);
    end
    pulse_rd();
    send_frame(8'h5A, 8, 0, 0, 1, 0, rise);
    idle(4);
    checks++;
    if (data !== 8'h5A) begin
      errors++;
      $display("FAIL break_next: got %h expected 5a", data);
    end
    checks++;
    if (state !== 8'h0A) begin
      errors++;
      $display("FAIL break_sticky: got %h expected 0a", state);
    end
    pulse_clr();
    pulse_rd();
  endtask

  task automatic test_parity();
    int rise;
    ctrl = 8'h05;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 8, 1, 0, 1, 0, rise);
    idle(4);
    checks++;
    if (rise !== 87) begin
      errors++;
      $display("FAIL par_latency: got %0d expected 87", rise);
    end
    checks++;
    if (state[4] !== 1'b1) begin
      errors++;
      $display("FAIL par_bad: got %b expected 1", state[4]);
    end
    pulse_clr();
    pulse_rd();
    send_frame(8'h07, 8, 1, 1, 1, 0, rise);
    idle(4);
    checks++;
    if (state[4] !== 1'b0) begin
      errors++;
      $display("FAIL par_good: got %b expected 0", state[4]);
    end
    pulse_rd();
    ctrl = 8'h07;
    send_frame(8'h07, 8, 1, 0, 1, 0, rise);
    idle(4);
    checks++;
    if (state[4] !== 1'b0) begin
      errors++;
      $display("FAIL par_odd: got %b expected 0", state[4]);
    end
`else
    send_frame(8'h07, 8, 0, 0, 1, 0, rise);
    idle(4);
    checks++;
    if (rise !== 79) begin
      errors++;
      $display("FAIL nopar_latency: got %0d expected 79", rise);
    end
    checks++;
    if (state[4] !== 1'b0) begin
      errors++;
      $display("FAIL nopar_flag: got %b expected 0", state[4]);
    end
`endif
    checks++;
    if (data !== 8'h07) begin
      errors++;
      $display("FAIL par_data: got %h expected 07", data);
    end
    pulse_rd();
    ctrl = 8'h01;
  endtask

  task automatic test_reset_mid();
    int rise;
    pin = 1'b0;
    repeat (30) tick();
    #2;
    resetn = 1'b1;
    #1;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data: got %h expected 00", data);
    end
    checks++;
    if (state !== 8'h00) begin
      errors++;
      $display("FAIL midreset_state: got %h expected 00", state);
    end
    pin = 1'b1;
    repeat (2) tick();
    resetn = 1'b0;
    idle(12);
    send_frame(8'h3C, 8, 0, 0, 1, 0, rise);
    idle(4);
    checks++;
    if (data !== 8'h3C) begin
      errors++;
      $display("FAIL midreset_next: got %h expected 3c", data);
    end
    checks++;
    if (state !== 8'h02) begin
      errors++;
      $display("FAIL midreset_flags: got %h expected 02", state);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_min_div();
    test_back_to_back();
    test_break();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
